// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg
//   Shared constants for the Wishbone GPIO bank: register word indices
//   (wb_adr_i[4:2]), register reset values, the maximum pin count and a
//   helper that expands Wishbone byte selects into a 32-bit lane mask.
package wb_gpio_pkg;

    localparam int MAX_WIDTH = 32;

    // Word index of each register inside the 32-byte window
    localparam logic [2:0] REG_IN       = 3'd0;
    localparam logic [2:0] REG_OUT      = 3'd1;
    localparam logic [2:0] REG_DIR      = 3'd2;
    localparam logic [2:0] REG_SET      = 3'd3;
    localparam logic [2:0] REG_CLR      = 3'd4;
    localparam logic [2:0] REG_IRQ_EN   = 3'd5;
    localparam logic [2:0] REG_IRQ_EDGE = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    localparam logic [MAX_WIDTH-1:0] RST_OUT      = '0;
    localparam logic [MAX_WIDTH-1:0] RST_DIR      = '0;
    localparam logic [MAX_WIDTH-1:0] RST_IRQ_EN   = '0;
    localparam logic [MAX_WIDTH-1:0] RST_IRQ_EDGE = '0;
    localparam logic [MAX_WIDTH-1:0] RST_IRQ_STAT = '0;

    function automatic logic [MAX_WIDTH-1:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
//   Multi-stage synchroniser for asynchronous pad inputs, plus (when
//   WB_GPIO_IRQ_EN is defined) one extra registered copy of the synced
//   value used to produce per-bit rising/falling edge pulses.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   din   - asynchronous pad inputs
//   sync  - value after STAGES flops
//   rise  - sync & ~prev   (WB_GPIO_IRQ_EN builds only)
//   fall  - ~sync & prev   (WB_GPIO_IRQ_EN builds only)
module gpio_sync_edge #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync
`ifdef WB_GPIO_IRQ_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    // Stage 0 samples the pads; stage STAGES-1 is the safe output
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign sync = sync_q[STAGES-1];

`ifdef WB_GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync;
        end
    end

    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;
`endif

endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank
//   Wishbone B4 classic slave GPIO bank, 32-byte window, 8 word registers:
//   IN, OUT, DIR, SET, CLR, IRQ_EN, IRQ_EDGE, IRQ_STAT (W1C).
//   Optional edge interrupts are built only when WB_GPIO_IRQ_EN is defined;
//   otherwise offsets 0x14..0x1C read 0, ignore writes, and irq_o is 0.
// Ports:
//   clk_i, rst_n_i        - clock, synchronous active-low reset
//   wb_cyc_i .. wb_dat_i  - Wishbone request (only wb_adr_i[4:2] decoded)
//   wb_dat_o, wb_ack_o    - registered read data and one-cycle ack
//   gpio_i                - asynchronous pad inputs
//   gpio_o, gpio_oe_o     - pad output values / enables (1 = drive)
//   irq_o                 - level interrupt, registered
module wb_gpio_bank
    import wb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  irq_o
);

    logic [GPIO_WIDTH-1:0] out_q, dir_q, pin_sync;
    logic [MAX_WIDTH-1:0]  lm32, wd32, rdata;
    logic [GPIO_WIDTH-1:0] lm, wd;
    logic [31:0]           dat_q;
    logic [2:0]            idx;
    logic                  ack_q, req, wr;
    logic                  unused_bits;

    // Suppressing a new request while ack is high yields ack every other
    // cycle for a held strobe.
    assign req  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr   = req & wb_we_i;
    assign idx  = wb_adr_i[4:2];
    assign lm32 = lane_mask(wb_sel_i);
    // Unselected bytes read as zero, which is what SET/CLR/W1C need
    assign wd32 = wb_dat_i & lm32;
    assign lm   = lm32[GPIO_WIDTH-1:0];
    assign wd   = wd32[GPIO_WIDTH-1:0];

    assign unused_bits = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0]};

`ifdef WB_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] rise, fall, edge_hit, w1c;
    logic [GPIO_WIDTH-1:0] en_q, edge_q, stat_q;
    logic                  irq_q;

    gpio_sync_edge #(.WIDTH(GPIO_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (gpio_i),
        .sync  (pin_sync),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_hit = (edge_q & rise) | (~edge_q & fall);
    assign w1c      = (wr && idx == REG_IRQ_STAT) ? wd : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en_q   <= RST_IRQ_EN[GPIO_WIDTH-1:0];
            edge_q <= RST_IRQ_EDGE[GPIO_WIDTH-1:0];
            stat_q <= RST_IRQ_STAT[GPIO_WIDTH-1:0];
            irq_q  <= 1'b0;
        end else begin
            if (wr && idx == REG_IRQ_EN)   en_q   <= (en_q & ~lm) | wd;
            if (wr && idx == REG_IRQ_EDGE) edge_q <= (edge_q & ~lm) | wd;
            // Clear first, then OR in new edges: a same-cycle edge wins
            stat_q <= (stat_q & ~w1c) | (edge_hit & en_q);
            irq_q  <= |(stat_q & en_q);
        end
    end

    assign irq_o = irq_q;
`else
    gpio_sync_edge #(.WIDTH(GPIO_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (gpio_i),
        .sync  (pin_sync)
    );

    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            REG_IN:       rdata[GPIO_WIDTH-1:0] = pin_sync;
            REG_OUT:      rdata[GPIO_WIDTH-1:0] = out_q;
            REG_DIR:      rdata[GPIO_WIDTH-1:0] = dir_q;
`ifdef WB_GPIO_IRQ_EN
            REG_IRQ_EN:   rdata[GPIO_WIDTH-1:0] = en_q;
            REG_IRQ_EDGE: rdata[GPIO_WIDTH-1:0] = edge_q;
            REG_IRQ_STAT: rdata[GPIO_WIDTH-1:0] = stat_q;
`endif
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            out_q <= RST_OUT[GPIO_WIDTH-1:0];
            dir_q <= RST_DIR[GPIO_WIDTH-1:0];
        end else begin
            ack_q <= req;
            dat_q <= (req && !wb_we_i) ? rdata : '0;
            if (wr) begin
                case (idx)
                    REG_OUT: out_q <= (out_q & ~lm) | wd;
                    REG_DIR: dir_q <= (dir_q & ~lm) | wd;
                    REG_SET: out_q <= out_q | wd;
                    REG_CLR: out_q <= out_q & ~wd;
                    default: ;
                endcase
            end
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
module tb_wb_gpio_bank;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]   adr = '0, dat_i = '0;
    logic [3:0]    sel = '0;
    logic [31:0]   dat_o;
    logic          ack;
    logic [W-1:0]  gpio_i = '0, gpio_o, gpio_oe;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_gpio_bank #(.GPIO_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (dat_i),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    // One classic cycle; returns read data and the ack level one cycle
    // after the handshake. A missing ack is counted as a failure.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic extra);
        logic got;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        got = 1'b0;
        rd  = 'x;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                rd  = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL bus_timeout adr=%h: no ack within 8 cycles", a);
        end
        @(posedge clk); #1;
        extra = ack;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        x;
        bus(1'b1, a, d, s, rd, x);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        logic x;
        bus(1'b0, a, 32'h0, 4'hF, d, x);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        x;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus ack=%b dat=%h, expected 0/0", ack, dat_o);
        end
        n_checks++;
        if (gpio_o !== '0 || gpio_oe !== '0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_pins o=%h oe=%h irq=%b, expected 0", gpio_o, gpio_oe, irq);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 32'(i * 4), 32'h0, 4'hF, d, x);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL reset_read off=%0h got %h, expected 00000000", i * 4, d);
            end
            n_checks++;
            if (x !== 1'b0) begin
                n_fail++; $display("FAIL reset_ack_len off=%0h ack still %b, expected 0", i * 4, x);
            end
        end
    endtask

    task automatic test_out_set_clr;
        logic [31:0] d;
        wr(32'h08, 32'h0000_00FF, 4'hF);
        wr(32'h04, 32'h0000_00A5, 4'hF);
        wr(32'h0C, 32'h0000_0100, 4'hF);
        wr(32'h10, 32'h0000_0001, 4'hF);
        rd(32'h04, d);
        n_checks++;
        if (d !== 32'h0000_01A4) begin
            n_fail++; $display("FAIL out_readback got %h, expected 000001a4", d);
        end
        n_checks++;
        if (gpio_o !== 32'h0000_01A4 || gpio_oe !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL out_pins o=%h oe=%h, expected 000001a4/000000ff", gpio_o, gpio_oe);
        end
        rd(32'h0C, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL set_reads_zero got %h, expected 0", d);
        end
        rd(32'h00, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL in_idle got %h, expected 0", d);
        end
        // Write to RO IN is acked and ignored
        wr(32'h00, 32'hFFFF_FFFF, 4'hF);
        rd(32'h00, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL in_ro got %h, expected 0", d);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        wr(32'h04, 32'h0, 4'hF);
        wr(32'h04, 32'hFFFF_FFFF, 4'b0010);
        rd(32'h04, d);
        n_checks++;
        if (d !== 32'h0000_FF00) begin
            n_fail++; $display("FAIL lane_out got %h, expected 0000ff00", d);
        end
        wr(32'h0C, 32'hFFFF_FFFF, 4'b0001);
        rd(32'h04, d);
        n_checks++;
        if (d !== 32'h0000_FFFF) begin
            n_fail++; $display("FAIL lane_set got %h, expected 0000ffff", d);
        end
        wr(32'h10, 32'hFFFF_FFFF, 4'b0010);
        rd(32'h04, d);
        n_checks++;
        if (d !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL lane_clr got %h, expected 000000ff", d);
        end
        // Upper address bits alias onto the same window
        rd(32'h0000_0124, d);
        n_checks++;
        if (d !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL alias got %h, expected 000000ff", d);
        end
    endtask

    task automatic test_in;
        logic [31:0] d;
        @(posedge clk); #1;
        gpio_i = 32'h1234_5678;
        // Two sync flops: visible after the second edge, not the first
        @(posedge clk); #1;
        n_checks++;
        if (dut.pin_sync !== 32'h0) begin
            n_fail++; $display("FAIL in_latency1 got %h, expected 0", dut.pin_sync);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dut.pin_sync !== 32'h1234_5678) begin
            n_fail++; $display("FAIL in_latency2 got %h, expected 12345678", dut.pin_sync);
        end
        rd(32'h00, d);
        n_checks++;
        if (d !== 32'h1234_5678) begin
            n_fail++; $display("FAIL in_read got %h, expected 12345678", d);
        end
        gpio_i = '0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        logic [3:0] pat;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        n_checks++;
        if (pat !== 4'b0101) begin
            n_fail++; $display("FAIL held_stb ack pattern %b, expected 0101", pat);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++; $display("FAIL held_stb_tail ack=%b dat=%h, expected 0/0", ack, dat_o);
        end
    endtask

`ifdef WB_GPIO_IRQ_EN
    task automatic test_irq;
        logic [31:0] d;
        wr(32'h14, 32'h1, 4'hF);
        wr(32'h18, 32'h1, 4'hF);
        gpio_i[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0 || dut.stat_q !== 32'h1) begin
            n_fail++; $display("FAIL irq_edge3 irq=%b stat=%h, expected 0/00000001", irq, dut.stat_q);
        end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_edge4 irq=%b, expected 1", irq);
        end
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL irq_stat got %h, expected 00000001", d);
        end
        wr(32'h1C, 32'h1, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_w1c irq=%b, expected 0", irq);
        end
        // Falling edge with rising selected: no status
        gpio_i[0] = 1'b0;
        repeat (6) @(posedge clk);
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_fall stat=%h irq=%b, expected 0/0", d, irq);
        end
        // W1C lands on the edge the rising edge sets status: set wins
        @(posedge clk); #1;
        gpio_i[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1C; dat_i = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++; $display("FAIL collide_ack ack=%b, expected 1", ack);
        end
        @(posedge clk); #1;
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            n_fail++; $display("FAIL collide_stat stat=%h irq=%b, expected 00000001/1", d, irq);
        end
        // Disable masks irq but keeps status
        wr(32'h14, 32'h0, 4'hF);
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_mask stat=%h irq=%b, expected 00000001/0", d, irq);
        end
        wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
        gpio_i = '0;
        repeat (4) @(posedge clk);
    endtask
`else
    task automatic test_irq;
        logic [31:0] d;
        wr(32'h14, 32'hFFFF_FFFF, 4'hF);
        wr(32'h18, 32'hFFFF_FFFF, 4'hF);
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL noirq_en got %h, expected 0", d);
        end
        gpio_i = 32'hFFFF_FFFF;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL noirq_rise irq=%b, expected 0", irq);
        end
        gpio_i = '0;
        repeat (5) @(posedge clk);
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL noirq_stat stat=%h irq=%b, expected 0/0", d, irq);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] d;
        // Start from a clean reset so OUT is known to be 0
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr(32'h08, 32'h0000_00FF, 4'hF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h04; dat_i = 32'hDEAD_BEEF; sel = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b0 || gpio_o !== '0 || gpio_oe !== '0) begin
            n_fail++; $display("FAIL rst_mid ack=%b o=%h oe=%h, expected 0/0/0", ack, gpio_o, gpio_oe);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(32'h04, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_out got %h, expected 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_out_set_clr();
        test_byte_lanes();
        test_in();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
